// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution unit:
// opcode/funct3 constants, B-immediate extraction and counter helpers.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] FNC_BEQ  = 3'b000;
  localparam logic [2:0] FNC_BNE  = 3'b001;
  localparam logic [2:0] FNC_BLT  = 3'b100;
  localparam logic [2:0] FNC_BGE  = 3'b101;
  localparam logic [2:0] FNC_BLTU = 3'b110;
  localparam logic [2:0] FNC_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_WNT = 2'b01;

  function automatic logic [12:0] b_imm(
    input logic [31:0] i
  );
    return {i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic ctr_t SAT_INC(input ctr_t c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic ctr_t SAT_DEC(input ctr_t c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Branch comparator: equality and signed/unsigned less-than.
// brun selects the unsigned compare.
module branch_cmp
  #(parameter int XLEN = 32)
  (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            brun,
    output logic            eq,
    output logic            lt
  );

  assign eq = (a == b);
  assign lt = brun ? (a < b)
                   : ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with a registered result stage,
// bimodal predictor training and mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
  #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PC_LSB    = 2,
    parameter int CNT_W     = 32
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_branch,
    output logic             illegal,
    output logic             taken,
    output logic             brun,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
  );

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            br;
  logic            ill;
  logic            unsig;
  logic            eq;
  logic            lt;
  logic            tk;
  logic            redir;
  logic            acc;
  logic [12:0]     imm;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall;
  logic [XLEN-1:0] npc;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic            unused_ok;

  ctr_t bht [BHT_DEPTH];

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign br     = (opcode == OPC_BRANCH);
  assign ill    = br && (funct3[2:1] == 2'b01);
  assign unsig  = br && (funct3[2:1] == 2'b11);

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .a    (rs1_data),
    .b    (rs2_data),
    .brun (unsig),
    .eq   (eq),
    .lt   (lt)
  );

  always_comb begin
    tk = 1'b0;
    if (br) begin
      unique case (funct3)
        FNC_BEQ:           tk = eq;
        FNC_BNE:           tk = !eq;
        FNC_BLT, FNC_BLTU: tk = lt;
        FNC_BGE, FNC_BGEU: tk = !lt;
        default:           tk = 1'b0;
      endcase
    end
  end

  assign imm    = b_imm(inst);
  assign imm_x  = {{(XLEN-13){imm[12]}}, imm};
  assign target = pc + imm_x;
  assign fall   = pc + XLEN'(4);
  assign npc    = tk ? target : fall;
  assign redir  = br && (tk != pred_taken);

  assign in_ready = !rst && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;

  assign widx         = pc[PC_LSB +: IDX_W];
  assign ridx         = lookup_pc[PC_LSB +: IDX_W];
  assign lookup_taken = bht[ridx][1];

  // rs fields are consumed upstream; only the index bits of lookup_pc matter
  assign unused_ok = ^{inst[24:15], lookup_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      is_branch        <= 1'b0;
      illegal          <= 1'b0;
      taken            <= 1'b0;
      brun             <= 1'b0;
      redirect         <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= CTR_WNT;
    end else begin
      if (acc) begin
        out_valid   <= 1'b1;
        is_branch   <= br;
        illegal     <= ill;
        taken       <= tk;
        brun        <= unsig;
        redirect    <= redir;
        redirect_pc <= npc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc && br) begin
        if (branch_count != '1)
          branch_count <= branch_count + CNT_W'(1);
        if (redir && mispredict_count != '1)
          mispredict_count <= mispredict_count + CNT_W'(1);
        if (!ill)
          bht[widx] <= tk ? SAT_INC(bht[widx])
                          : SAT_DEC(bht[widx]);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (XLEN=32).
// Each task drives one scenario and checks results inline.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic        is_branch;
  logic        illegal;
  logic        taken;
  logic        brun;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .inst             (inst),
    .pc               (pc),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .pred_taken       (pred_taken),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .is_branch        (is_branch),
    .illegal          (illegal),
    .taken            (taken),
    .brun             (brun),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .lookup_pc        (lookup_pc),
    .lookup_taken     (lookup_taken),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  function automatic logic [31:0] enc(
    input logic [2:0]  f3,
    input logic [12:0] im
  );
    return {im[12], im[10:5], 5'd2, 5'd1, f3,
            im[4:1], im[11], 7'b1100011};
  endfunction

  // Present one instruction and wait (bounded) for acceptance;
  // returns at the negedge after the accepting edge.
  task automatic send(
    input logic [31:0] i,
    input logic [31:0] p,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        pt
  );
    bit ok;
    ok = 0;
    inst = i; pc = p;
    rs1_data = a; rs2_data = b;
    pred_taken = pt; in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_timeout pc=%h not accepted in 20 cycles", p);
    end
  endtask

  task automatic check_counts(input string nm);
    n_cmp++;
    if (branch_count !== 32'(exp_br)) begin
      n_bad++;
      $display("FAIL %s branch_count got %0d exp %0d",
               nm, branch_count, exp_br);
    end
    n_cmp++;
    if (mispredict_count !== 32'(exp_mp)) begin
      n_bad++;
      $display("FAIL %s mispredict_count got %0d exp %0d",
               nm, mispredict_count, exp_mp);
    end
  endtask

  task automatic test_reset;
    int bad_idx;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    pred_taken = 1'b0; lookup_pc = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out got v=%b pc=%h exp 0/0",
               out_valid, redirect_pc);
    end
    n_cmp++;
    if ({is_branch, illegal, taken, brun, redirect} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b exp 00000",
               {is_branch, illegal, taken, brun, redirect});
    end
    exp_br = 0; exp_mp = 0;
    check_counts("reset");
    bad_idx = 0;
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      if (lookup_taken !== 1'b0) bad_idx++;
    end
    n_cmp++;
    if (bad_idx != 0) begin
      n_bad++;
      $display("FAIL reset_bht got %0d taken entries exp 0", bad_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_signed_unsigned;
    send(enc(3'b100, 13'd16), 32'h100,
         32'hFFFF_FFFF, 32'h1, 1'b0);
    exp_br++; exp_mp++;
    n_cmp++;
    if ({out_valid, is_branch, taken, brun, redirect} !== 5'b11101) begin
      n_bad++;
      $display("FAIL blt_flags got %b exp 11101",
               {out_valid, is_branch, taken, brun, redirect});
    end
    n_cmp++;
    if (redirect_pc !== 32'h110) begin
      n_bad++;
      $display("FAIL blt_redirect_pc got %h exp 00000110", redirect_pc);
    end
    check_counts("blt");
    send(enc(3'b110, 13'd16), 32'h100,
         32'hFFFF_FFFF, 32'h1, 1'b0);
    exp_br++;
    n_cmp++;
    if ({is_branch, taken, brun, redirect} !== 4'b1010) begin
      n_bad++;
      $display("FAIL bltu_flags got %b exp 1010",
               {is_branch, taken, brun, redirect});
    end
    n_cmp++;
    if (redirect_pc !== 32'h104) begin
      n_bad++;
      $display("FAIL bltu_redirect_pc got %h exp 00000104", redirect_pc);
    end
    check_counts("bltu");
    // BGE equal operands, most negative offset
    send(enc(3'b101, 13'h1000), 32'h2000, 32'h5, 32'h5, 1'b1);
    exp_br++;
    n_cmp++;
    if ({taken, brun, redirect} !== 3'b100 ||
        redirect_pc !== 32'h1000) begin
      n_bad++;
      $display("FAIL bge_neg got t/u/r=%b pc=%h exp 100 00001000",
               {taken, brun, redirect}, redirect_pc);
    end
    // BGEU: 1 >= 0xFFFFFFFF unsigned is false
    send(enc(3'b111, 13'd8), 32'h300, 32'h1, 32'hFFFF_FFFF, 1'b1);
    exp_br++; exp_mp++;
    n_cmp++;
    if ({taken, brun, redirect} !== 3'b011 ||
        redirect_pc !== 32'h304) begin
      n_bad++;
      $display("FAIL bgeu got t/u/r=%b pc=%h exp 011 00000304",
               {taken, brun, redirect}, redirect_pc);
    end
    check_counts("bgeu");
  endtask

  task automatic test_bht_train;
    logic [2:0] want;
    lookup_pc = 32'h40;
    #1;
    n_cmp++;
    if (lookup_taken !== 1'b0) begin
      n_bad++;
      $display("FAIL bht_init got %b exp 0", lookup_taken);
    end
    want = 3'b111;
    for (int k = 0; k < 3; k++) begin
      send(enc(3'b000, 13'd32), 32'h40, 32'h7, 32'h7, 1'b1);
      exp_br++;
      n_cmp++;
      if (lookup_taken !== want[k] || taken !== 1'b1 ||
          redirect_pc !== 32'h60) begin
        n_bad++;
        $display("FAIL bht_beq%0d got lt=%b t=%b pc=%h exp 1 1 00000060",
                 k, lookup_taken, taken, redirect_pc);
      end
    end
    // counter now saturated at 11: one not-taken leaves it at 10
    send(enc(3'b001, 13'd32), 32'h40, 32'h7, 32'h7, 1'b0);
    exp_br++;
    n_cmp++;
    if (lookup_taken !== 1'b1 || taken !== 1'b0 ||
        redirect !== 1'b0) begin
      n_bad++;
      $display("FAIL bht_bne got lt=%b t=%b r=%b exp 1 0 0",
               lookup_taken, taken, redirect);
    end
    check_counts("bht");
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 1'b0;
    send(enc(3'b001, 13'h1FF8), 32'h200, 32'h1, 32'h2, 1'b1);
    exp_br++;
    inst = enc(3'b000, 13'd64); pc = 32'h300;
    rs1_data = 32'h1; rs2_data = 32'h2;
    pred_taken = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          taken !== 1'b1 || redirect_pc !== 32'h1F8) begin
        n_bad++;
        $display("FAIL bp_hold%0d got rdy=%b v=%b t=%b pc=%h exp 0 1 1 000001f8",
                 k, in_ready, out_valid, taken, redirect_pc);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_ready got %b exp 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_br++;
    n_cmp++;
    if (out_valid !== 1'b1 || taken !== 1'b0 ||
        redirect_pc !== 32'h304) begin
      n_bad++;
      $display("FAIL bp_second got v=%b t=%b pc=%h exp 1 0 00000304",
               out_valid, taken, redirect_pc);
    end
    check_counts("bp");
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_illegal;
    lookup_pc = 32'h40;
    send(enc(3'b010, 13'd16), 32'h40, 32'h1, 32'h1, 1'b1);
    exp_br++; exp_mp++;
    n_cmp++;
    if ({is_branch, illegal, taken, brun, redirect} !== 5'b11001 ||
        redirect_pc !== 32'h44) begin
      n_bad++;
      $display("FAIL illegal010 got %b pc=%h exp 11001 00000044",
               {is_branch, illegal, taken, brun, redirect}, redirect_pc);
    end
    n_cmp++;
    if (lookup_taken !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_bht got %b exp 1", lookup_taken);
    end
    check_counts("illegal");
    send(enc(3'b001, 13'd16), 32'h40, 32'h1, 32'h1, 1'b0);
    exp_br++;
    n_cmp++;
    if (lookup_taken !== 1'b0) begin
      n_bad++;
      $display("FAIL bht_dec got %b exp 0", lookup_taken);
    end
    send(enc(3'b011, 13'd16), 32'hFFFF_FFFC, 32'h1, 32'h1, 1'b1);
    exp_br++; exp_mp++;
    n_cmp++;
    if (illegal !== 1'b1 || redirect !== 1'b1 ||
        redirect_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL illegal011_wrap got i=%b r=%b pc=%h exp 1 1 00000000",
               illegal, redirect, redirect_pc);
    end
    send(enc(3'b000, 13'd32), 32'hFFFF_FFF0, 32'h9, 32'h9, 1'b0);
    exp_br++; exp_mp++;
    n_cmp++;
    if (taken !== 1'b1 || redirect_pc !== 32'h10) begin
      n_bad++;
      $display("FAIL target_wrap got t=%b pc=%h exp 1 00000010",
               taken, redirect_pc);
    end
    check_counts("wrap");
  endtask

  task automatic test_non_branch;
    send(32'h0000_0013, 32'h80, 32'h1, 32'h1, 1'b1);
    n_cmp++;
    if ({out_valid, is_branch, illegal, taken, redirect} !== 5'b10000) begin
      n_bad++;
      $display("FAIL non_branch got %b exp 10000",
               {out_valid, is_branch, illegal, taken, redirect});
    end
    check_counts("non_branch");
  endtask

  task automatic test_reset_mid;
    send(enc(3'b000, 13'd8), 32'h40, 32'h3, 32'h3, 1'b1);
    exp_br++;
    inst = enc(3'b000, 13'd8); pc = 32'h40;
    rs1_data = 32'h3; rs2_data = 32'h3;
    pred_taken = 1'b0; in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    lookup_pc = 32'h40;
    #1;
    exp_br = 0; exp_mp = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        lookup_taken !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got v=%b rdy=%b lt=%b exp 0 1 0",
               out_valid, in_ready, lookup_taken);
    end
    check_counts("mid_reset");
  endtask

  initial begin
    test_reset();
    test_signed_unsigned();
    test_bht_train();
    test_backpressure();
    test_illegal();
    test_non_branch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised execute-stage branch resolution unit: classifies and evaluates RV32/RV64 conditional branches, computes target and redirect, and trains a direct-mapped 2-bit bimodal predictor table. Sits between decode/register read and the PC-select/flush logic. One-deep registered pipeline stage with valid/ready handshake. Also supplies the branch-comparator unsigned-select signal and mispredict statistics.

## Interface
- XLEN, 32: data and PC width (32 or 64)
- BHT_DEPTH, 64: predictor entries; power of 2, ≥ 2
- PC_LSB, 2: lowest PC bit used for BHT index
- CNT_W, 32: statistics counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept
- inst  in  32  instruction word
- pc  in  XLEN  instruction PC
- rs1_data, rs2_data  in  XLEN  operands
- pred_taken  in  1  fetch-time prediction for this instruction
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts result
- is_branch  out  1  opcode == OPC_BRANCH
- illegal  out  1  branch opcode with funct3 010 or 011
- taken  out  1  resolved direction
- brun  out  1  unsigned compare selected (BLTU/BGEU)
- redirect  out  1  misprediction; flush and refetch
- redirect_pc  out  XLEN  correct next PC
- lookup_pc  in  XLEN  fetch-side prediction query
- lookup_taken  out  1  MSB of indexed counter
- branch_count, mispredict_count  out  CNT_W  statistics

## Operation
- Accept = in_valid && in_ready; in_ready = !rst && (!out_valid || out_ready).
- On accept, all result fields are computed from inputs and registered; out_valid set. On out_valid && out_ready with no accept, out_valid clears; with accept, it stays set (back-to-back).
- funct3 decode: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. brun=1 only for 110/111, else 0 (never X).
- Illegal (010/011): taken=0, illegal=1; no BHT update; counted in branch_count.
- Non-branch opcode: is_branch=0, taken=0, redirect=0, illegal=0; no BHT or counter update.
- target = pc + sext(B-imm {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}), modulo 2^XLEN. fallthrough = pc + 4, modulo 2^XLEN.
- redirect = is_branch && (taken != pred_taken); redirect_pc = taken ? target : fallthrough (valid whenever is_branch).
- BHT: BHT_DEPTH × 2-bit saturating counters, index = pc[PC_LSB +: log2(BHT_DEPTH)]. Legal branch accept: taken → inc (sat 11), not taken → dec (sat 00).
- lookup_taken combinational from lookup_pc; no write bypass (update visible the cycle after accept).
- branch_count +1 per accepted branch (incl. illegal); mispredict_count +1 per accepted redirect; both saturate at all-ones.

## Timing
- Latency: 1 cycle accept→out_valid. Throughput: 1/cycle while out_ready=1.
- Output register holds value stable while out_valid && !out_ready.
- Reset: out_valid, is_branch, illegal, taken, brun, redirect = 0; redirect_pc = 0; counts = 0; every BHT entry = 01 (weakly not taken); in_ready = 0 during rst.
- Reset mid-operation: pending result discarded, no count or BHT update that cycle; in_ready=1 first cycle after rst deasserts.
- Simultaneous lookup and update of same index: lookup returns pre-update value.

## Structure
- Shared package: OPC_BRANCH, FNC_BEQ/BNE/BLT/BGE/BLTU/BGEU constants, B-immediate extraction function, 2-bit counter typedef and SAT_INC/SAT_DEC helpers.
- One sub-module: branch_cmp (combinational, XLEN-parametrised eq/lt with unsigned select); BHT array and handshake stay in top.

## Test plan
- Reset: after rst, lookup_taken=0 for all indices, counts=0, out_valid=0; in_ready=0 while rst=1.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=+16, pred_taken=0 → taken=1, brun=0, redirect=1, redirect_pc=0x110, mispredict_count=1.
- BLTU same operands, pred_taken=0 → taken=0, brun=1, redirect=0, redirect_pc=0x104.
- Three taken BEQ at pc=0x40 → counter 01→10→11→11; lookup_taken=1 from cycle after first update.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, output stable, second instruction accepted on cycle out_ready=1.
- funct3=010 with pred_taken=1 → illegal=1, taken=0, redirect=1 to pc+4, BHT unchanged; pc=0xFFFFFFFC fallthrough wraps to 0.
